// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W         = 5;
  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned MULTI_LAT_DEF = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MULTI = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Per-stage strobe bundle produced each cycle by the controller.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_clear;
    logic idex_clear;
    logic exmem_clear;
  } strobe_t;

  // Everything advances, nothing is cleared.
  function automatic strobe_t strobe_run();
    strobe_t s;
    s = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
          memwb_en: 1'b1, ifid_clear: 1'b0, idex_clear: 1'b0,
          exmem_clear: 1'b0};
    return s;
  endfunction

  // Front-end held, bubble into MEM, WB keeps draining.
  function automatic strobe_t strobe_freeze();
    strobe_t s;
    s = strobe_run();
    s.pc_en       = 1'b0;
    s.ifid_en     = 1'b0;
    s.idex_en     = 1'b0;
    s.exmem_clear = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs from ID/EX and stage strobes/counters back to the datapath.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) ();

  logic [REG_W-1:0] id_req_a;
  logic [REG_W-1:0] id_req_b;
  logic             id_uses_a;
  logic             id_uses_b;
  logic             ex_r_datamem;
  logic             ex_regfile_w_en;
  logic [REG_W-1:0] ex_req_w;
  logic             ex_mispredict;
  logic             ex_syscall_halt;
  logic             ex_multi_start;
  logic             resume;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_clear;
  logic             idex_clear;
  logic             exmem_clear;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Datapath side: drives hazard info, consumes strobes.
  modport master (
    output id_req_a, id_req_b, id_uses_a, id_uses_b, ex_r_datamem,
           ex_regfile_w_en, ex_req_w, ex_mispredict, ex_syscall_halt,
           ex_multi_start, resume,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clear,
           idex_clear, exmem_clear, halted, stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  id_req_a, id_req_b, id_uses_a, id_uses_b, ex_r_datamem,
           ex_regfile_w_en, ex_req_w, ex_mispredict, ex_syscall_halt,
           ex_multi_start, resume,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clear,
           idex_clear, exmem_clear, halted, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_detect.sv
// Load-use comparator: a load in EX writes a register the ID instruction reads.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_req_a,
  input  logic [REG_W-1:0] id_req_b,
  input  logic             id_uses_a,
  input  logic             id_uses_b,
  input  logic             ex_r_datamem,
  input  logic             ex_regfile_w_en,
  input  logic [REG_W-1:0] ex_req_w,
  output logic             load_use
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  always_comb begin
    load_use = 1'b0;
    if (ex_r_datamem && ex_regfile_w_en && (ex_req_w != '0)) begin
      load_use = (id_uses_a && (id_req_a == ex_req_w)) ||
                 (id_uses_b && (id_req_b == ex_req_w));
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables/clears, halt and stall/flush
// counters. Define PIPE_CTRL_MULTI_EN to build multi-cycle EX freeze support.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULTI_LAT = MULTI_LAT_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_ctrl_if.slave   bus
);

  if (MULTI_LAT < 2) begin : g_bad_lat
    $error("pipe_ctrl: MULTI_LAT must be at least 2");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  strobe_t          stb_c;
  logic             halted_c;
  logic             flush_inc_c;
  logic             load_use;

`ifdef PIPE_CTRL_MULTI_EN
  localparam int unsigned MCNT_W = (MULTI_LAT > 2) ? $clog2(MULTI_LAT - 1) : 1;
  logic [MCNT_W-1:0] cnt_q, cnt_d;
`endif

  pipe_hazard_detect u_hazard (
    .id_req_a        (bus.id_req_a),
    .id_req_b        (bus.id_req_b),
    .id_uses_a       (bus.id_uses_a),
    .id_uses_b       (bus.id_uses_b),
    .ex_r_datamem    (bus.ex_r_datamem),
    .ex_regfile_w_en (bus.ex_regfile_w_en),
    .ex_req_w        (bus.ex_req_w),
    .load_use        (load_use)
  );

  // State register, multi-cycle countdown and performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
`ifdef PIPE_CTRL_MULTI_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
`ifdef PIPE_CTRL_MULTI_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Next state and strobes; priority in RUN is halt > mispredict > multi > load-use.
  always_comb begin
    state_d     = state_q;
    stb_c       = strobe_run();
    halted_c    = 1'b0;
    flush_inc_c = 1'b0;
`ifdef PIPE_CTRL_MULTI_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (bus.ex_syscall_halt) begin
          state_d = ST_HALT;
        end else if (bus.ex_mispredict) begin
          stb_c.ifid_clear = 1'b1;
          stb_c.idex_clear = 1'b1;
          flush_inc_c      = 1'b1;
`ifdef PIPE_CTRL_MULTI_EN
        end else if (bus.ex_multi_start) begin
          stb_c   = strobe_freeze();
          cnt_d   = MCNT_W'(MULTI_LAT - 2);
          state_d = ST_MULTI;
`endif
        end else if (load_use) begin
          stb_c.pc_en      = 1'b0;
          stb_c.ifid_en    = 1'b0;
          stb_c.idex_clear = 1'b1;
        end
      end
`ifdef PIPE_CTRL_MULTI_EN
      ST_MULTI: begin
        if (cnt_q != '0) begin
          stb_c = strobe_freeze();
          cnt_d = cnt_q - MCNT_W'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
`endif
      ST_HALT: begin
        stb_c    = strobe_freeze();
        halted_c = 1'b1;
        if (bus.resume) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Saturating counters; halted cycles are not counted as stalls.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!stb_c.pc_en && (state_q != ST_HALT) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_inc_c && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Strobes are forced low while reset is held.
  always_comb begin
    bus.pc_en       = rst_n & stb_c.pc_en;
    bus.ifid_en     = rst_n & stb_c.ifid_en;
    bus.idex_en     = rst_n & stb_c.idex_en;
    bus.exmem_en    = rst_n & stb_c.exmem_en;
    bus.memwb_en    = rst_n & stb_c.memwb_en;
    bus.ifid_clear  = rst_n & stb_c.ifid_clear;
    bus.idex_clear  = rst_n & stb_c.idex_clear;
    bus.exmem_clear = rst_n & stb_c.exmem_clear;
    bus.halted      = rst_n & halted_c;
    bus.stall_cnt   = stall_cnt_q;
    bus.flush_cnt   = flush_cnt_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with 4-bit counters and MULTI_LAT=4.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

`ifdef PIPE_CTRL_MULTI_EN
  localparam bit MULTI_ON = 1'b1;
`else
  localparam bit MULTI_ON = 1'b0;
`endif

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_clr, exmem_clr, halted}
  localparam logic [8:0] S_RST    = 9'b000000000;
  localparam logic [8:0] S_RUN    = 9'b111110000;
  localparam logic [8:0] S_STALL  = 9'b001110100;
  localparam logic [8:0] S_FLUSH  = 9'b111111100;
  localparam logic [8:0] S_FREEZE = 9'b000110010;
  localparam logic [8:0] S_HALT   = 9'b000110011;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  pipe_ctrl_if #(.CNT_W(4)) bus ();

  pipe_ctrl #(.MULTI_LAT(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] strobes();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_clear, bus.idex_clear, bus.exmem_clear, bus.halted};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_req_a        = '0;
    bus.id_req_b        = '0;
    bus.id_uses_a       = 1'b0;
    bus.id_uses_b       = 1'b0;
    bus.ex_r_datamem    = 1'b0;
    bus.ex_regfile_w_en = 1'b0;
    bus.ex_req_w        = '0;
    bus.ex_mispredict   = 1'b0;
    bus.ex_syscall_halt = 1'b0;
    bus.ex_multi_start  = 1'b0;
    bus.resume          = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                        input logic ua, input logic ub, input logic wen);
    bus.ex_r_datamem    = 1'b1;
    bus.ex_regfile_w_en = wen;
    bus.ex_req_w        = rd;
    bus.id_req_a        = ra;
    bus.id_req_b        = rb;
    bus.id_uses_a       = ua;
    bus.id_uses_b       = ub;
  endtask

  // All EX-sourced inputs active at once; HALT must ignore them.
  task automatic noise();
    set_lu(5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1);
    bus.ex_mispredict  = 1'b1;
    bus.ex_multi_start = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    chk("reset_strobes", 32'(strobes()), 32'(S_RST));
    chk("reset_stall",   32'(bus.stall_cnt), 32'd0);
    chk("reset_flush",   32'(bus.flush_cnt), 32'd0);

    nxt(); rst_n = 1'b1;
    #1 chk("run_default", 32'(strobes()), 32'(S_RUN));

    // Load-use on source A
    nxt(); set_lu(5'd8, 5'd8, 5'd3, 1'b1, 1'b0, 1'b1);
    #1 chk("lu_a_stall", 32'(strobes()), 32'(S_STALL));
    nxt();
    #1 chk("lu_a_after", 32'(strobes()), 32'(S_RUN));
    chk("lu_a_stall_cnt", 32'(bus.stall_cnt), 32'd1);

    // Non-hazards
    nxt(); set_lu(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    #1 chk("lu_r0", 32'(strobes()), 32'(S_RUN));
    nxt(); set_lu(5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b1);
    #1 chk("lu_unused", 32'(strobes()), 32'(S_RUN));
    nxt(); set_lu(5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
    #1 chk("lu_no_wen", 32'(strobes()), 32'(S_RUN));

    // Load-use on source B
    nxt(); set_lu(5'd17, 5'd2, 5'd17, 1'b1, 1'b1, 1'b1);
    #1 chk("lu_b_stall", 32'(strobes()), 32'(S_STALL));
    nxt();
    #1 chk("lu_b_stall_cnt", 32'(bus.stall_cnt), 32'd2);

    // Mispredict suppresses load-use
    nxt(); set_lu(5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1); bus.ex_mispredict = 1'b1;
    #1 chk("mp_lu", 32'(strobes()), 32'(S_FLUSH));
    nxt();
    #1 chk("mp_after", 32'(strobes()), 32'(S_RUN));
    chk("mp_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    chk("mp_stall_cnt", 32'(bus.stall_cnt), 32'd2);

    // Syscall beats mispredict; HALT ignores EX inputs
    nxt(); bus.ex_syscall_halt = 1'b1; bus.ex_mispredict = 1'b1;
    #1 chk("sys_cycle", 32'(strobes()), 32'(S_RUN));
    nxt(); noise();
    #1 chk("halt_enter", 32'(strobes()), 32'(S_HALT));
    chk("halt_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    for (int i = 0; i < 9; i++) begin
      nxt(); noise();
      #1 chk("halt_hold", 32'(strobes()), 32'(S_HALT));
    end
    nxt(); noise(); bus.resume = 1'b1;
    #1 chk("halt_resume", 32'(strobes()), 32'(S_HALT));
    nxt();
    #1 chk("resumed", 32'(strobes()), 32'(S_RUN));
    chk("halt_stall_cnt", 32'(bus.stall_cnt), 32'd2);
    chk("halt_flush_cnt2", 32'(bus.flush_cnt), 32'd1);

    // Resume in the first HALT cycle gives a one-cycle dwell
    nxt(); bus.ex_syscall_halt = 1'b1;
    #1 chk("sys2_cycle", 32'(strobes()), 32'(S_RUN));
    nxt(); bus.resume = 1'b1;
    #1 chk("dwell1_halt", 32'(strobes()), 32'(S_HALT));
    nxt();
    #1 chk("dwell1_run", 32'(strobes()), 32'(S_RUN));

    // Resume in RUN has no effect
    nxt(); bus.resume = 1'b1;
    #1 chk("resume_run", 32'(strobes()), 32'(S_RUN));
    nxt();
    #1 chk("resume_run_after", 32'(strobes()), 32'(S_RUN));

    // Mispredict beats multi-cycle start
    nxt(); bus.ex_mispredict = 1'b1; bus.ex_multi_start = 1'b1;
    #1 chk("mp_multi", 32'(strobes()), 32'(S_FLUSH));
    nxt();
    #1 chk("mp_multi_after", 32'(strobes()), 32'(S_RUN));
    chk("mp_multi_flush", 32'(bus.flush_cnt), 32'd2);

    // Multi-cycle op: three freeze cycles when built in, none otherwise
    nxt(); bus.ex_multi_start = 1'b1;
    #1 chk("multi_c0", 32'(strobes()), 32'(MULTI_ON ? S_FREEZE : S_RUN));
    nxt();
    #1 chk("multi_c1", 32'(strobes()), 32'(MULTI_ON ? S_FREEZE : S_RUN));
    nxt();
`ifdef PIPE_CTRL_MULTI_EN
    bus.ex_mispredict = 1'b1;
`endif
    #1 chk("multi_c2", 32'(strobes()), 32'(MULTI_ON ? S_FREEZE : S_RUN));
    nxt();
    #1 chk("multi_done", 32'(strobes()), 32'(S_RUN));
    chk("multi_stall_cnt", 32'(bus.stall_cnt), MULTI_ON ? 32'd5 : 32'd2);
    chk("multi_flush_cnt", 32'(bus.flush_cnt), 32'd2);

    // Flush counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      nxt(); bus.ex_mispredict = 1'b1;
      #1 chk("sat_flush", 32'(strobes()), 32'(S_FLUSH));
    end
    nxt();
    #1 chk("sat_flush_cnt", 32'(bus.flush_cnt), 32'd15);

    // Asynchronous reset mid-MULTI
    nxt(); bus.ex_multi_start = 1'b1;
    nxt(); rst_n = 1'b0;
    #1 chk("rst_multi_strobes", 32'(strobes()), 32'(S_RST));
    chk("rst_multi_stall", 32'(bus.stall_cnt), 32'd0);
    chk("rst_multi_flush", 32'(bus.flush_cnt), 32'd0);
    nxt(); rst_n = 1'b1;
    #1 chk("rst_multi_run", 32'(strobes()), 32'(S_RUN));

    // Asynchronous reset mid-HALT
    nxt(); bus.ex_syscall_halt = 1'b1;
    nxt();
    #1 chk("rst_halt_pre", 32'(strobes()), 32'(S_HALT));
    rst_n = 1'b0;
    #1 chk("rst_halt_strobes", 32'(strobes()), 32'(S_RST));
    nxt(); rst_n = 1'b1;
    #1 chk("rst_halt_run", 32'(strobes()), 32'(S_RUN));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
